// File: rtl/mips_sopc.sv
// mips_sopc: minimal MIPS32 SoPC, a 5-stage integer core plus a word-organised instruction ROM.
// Ports: clock (rising-edge system clock), reset (asynchronous, active-low).
// Benches preload rom.storage and observe cpu.register.storage hierarchically.

// Purpose: instruction ROM with a combinational word read; output forced to 0 while fetch is disabled.
// Latency: 0 cycles (combinational).
// Backpressure: none; a read is served every cycle.
module mips_rom #(
    parameter int DEPTH = 1024
) (
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    output logic [31:0] inst_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   storage [0:DEPTH-1];
    logic [AW-1:0] word_idx;
    logic          unused_addr_bits;

    // DEPTH is a power of two, so dropping the high PC bits gives the modulo-DEPTH wrap.
    assign word_idx         = addr_i[AW+1:2];
    assign inst_o           = ce_i ? storage[word_idx] : 32'h0;
    assign unused_addr_bits = ^{addr_i[31:AW+2], addr_i[1:0]};
endmodule

// Purpose: 32x32 general-purpose register file, two read ports, one write port, $0 hardwired to 0.
// Latency: write lands on the clock edge; reads are combinational with write-through of the pending write.
// Backpressure: none.
module mips_regfile (
    input  logic        clock,
    input  logic        reset,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);
    logic [31:0] storage [0:31];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                storage[i] <= 32'h0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            storage[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = storage[raddr1_i];
        if (raddr1_i == 5'd0) begin
            rdata1_o = 32'h0;
        end else if (we_i && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
    end

    always_comb begin
        rdata2_o = storage[raddr2_i];
        if (raddr2_i == 5'd0) begin
            rdata2_o = 32'h0;
        end else if (we_i && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end
endmodule

// Purpose: 5-stage (IF/ID/EX/MEM/WB) core for the MIPS32 logic, LUI and shift subset.
// Latency: instruction fetched after edge k writes its destination 5 edges after its fetch edge-1.
// Backpressure: none; no stalls, operands forwarded EX > MEM > register file.
module mips_core (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rom_inst_i,
    output logic [31:0] rom_addr_o,
    output logic        rom_ce_o
);
    typedef enum logic [2:0] {
        ALU_NOP, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;

    // IF
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_inst_q, if_id_inst_d;
    // ID/EX
    alu_op_e     id_ex_op_q, id_ex_op_d;
    logic [31:0] id_ex_a_q, id_ex_a_d;
    logic [31:0] id_ex_b_q, id_ex_b_d;
    logic        id_ex_wreg_q, id_ex_wreg_d;
    logic [4:0]  id_ex_waddr_q, id_ex_waddr_d;
    // EX/MEM
    logic        ex_mem_wreg_q, ex_mem_wreg_d;
    logic [4:0]  ex_mem_waddr_q, ex_mem_waddr_d;
    logic [31:0] ex_mem_wdata_q, ex_mem_wdata_d;
    // MEM/WB
    logic        mem_wb_wreg_q, mem_wb_wreg_d;
    logic [4:0]  mem_wb_waddr_q, mem_wb_waddr_d;
    logic [31:0] mem_wb_wdata_q, mem_wb_wdata_d;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [31:0] rs_val, rt_val;
    logic [31:0] ex_result;

    // Fetch is enabled exactly when reset is released, so the word at PC 0
    // is captured on the first edge after release.
    assign rom_ce_o   = reset;
    assign rom_addr_o = pc_q;

    always_comb begin
        pc_d         = pc_q + 32'd4;
        if_id_inst_d = rom_inst_i;
    end

    assign opcode = if_id_inst_q[31:26];
    assign rs     = if_id_inst_q[25:21];
    assign rt     = if_id_inst_q[20:16];
    assign rd     = if_id_inst_q[15:11];
    assign shamt  = if_id_inst_q[10:6];
    assign funct  = if_id_inst_q[5:0];
    assign imm    = if_id_inst_q[15:0];

    mips_regfile register (
        .clock    (clock),
        .reset    (reset),
        .we_i     (mem_wb_wreg_q),
        .waddr_i  (mem_wb_waddr_q),
        .wdata_i  (mem_wb_wdata_q),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    // Operand forwarding: the younger producer (in EX) wins over the older one (in MEM);
    // the WB producer is covered by the register file's write-through.
    always_comb begin
        rs_val = rf_rdata1;
        if (rs == 5'd0) begin
            rs_val = 32'h0;
        end else if (id_ex_wreg_q && (id_ex_waddr_q == rs)) begin
            rs_val = ex_result;
        end else if (ex_mem_wreg_q && (ex_mem_waddr_q == rs)) begin
            rs_val = ex_mem_wdata_q;
        end
    end

    always_comb begin
        rt_val = rf_rdata2;
        if (rt == 5'd0) begin
            rt_val = 32'h0;
        end else if (id_ex_wreg_q && (id_ex_waddr_q == rt)) begin
            rt_val = ex_result;
        end else if (ex_mem_wreg_q && (ex_mem_waddr_q == rt)) begin
            rt_val = ex_mem_wdata_q;
        end
    end

    // Decode. Shifts carry the shift amount in operand a and the value in operand b.
    // Anything not listed decodes to a no-op with no write.
    always_comb begin
        id_ex_op_d    = ALU_NOP;
        id_ex_a_d     = 32'h0;
        id_ex_b_d     = 32'h0;
        id_ex_wreg_d  = 1'b0;
        id_ex_waddr_d = 5'd0;
        case (opcode)
            6'h00: begin
                id_ex_waddr_d = rd;
                id_ex_b_d     = rt_val;
                id_ex_wreg_d  = 1'b1;
                case (funct)
                    6'h24:   begin id_ex_op_d = ALU_AND; id_ex_a_d = rs_val; end
                    6'h25:   begin id_ex_op_d = ALU_OR;  id_ex_a_d = rs_val; end
                    6'h26:   begin id_ex_op_d = ALU_XOR; id_ex_a_d = rs_val; end
                    6'h27:   begin id_ex_op_d = ALU_NOR; id_ex_a_d = rs_val; end
                    6'h00:   begin id_ex_op_d = ALU_SLL; id_ex_a_d = {27'h0, shamt}; end
                    6'h02:   begin id_ex_op_d = ALU_SRL; id_ex_a_d = {27'h0, shamt}; end
                    6'h03:   begin id_ex_op_d = ALU_SRA; id_ex_a_d = {27'h0, shamt}; end
                    6'h04:   begin id_ex_op_d = ALU_SLL; id_ex_a_d = rs_val; end
                    6'h06:   begin id_ex_op_d = ALU_SRL; id_ex_a_d = rs_val; end
                    6'h07:   begin id_ex_op_d = ALU_SRA; id_ex_a_d = rs_val; end
                    default: id_ex_wreg_d = 1'b0;
                endcase
            end
            6'h0C: begin
                id_ex_op_d = ALU_AND; id_ex_a_d = rs_val; id_ex_b_d = {16'h0, imm};
                id_ex_waddr_d = rt; id_ex_wreg_d = 1'b1;
            end
            6'h0D: begin
                id_ex_op_d = ALU_OR; id_ex_a_d = rs_val; id_ex_b_d = {16'h0, imm};
                id_ex_waddr_d = rt; id_ex_wreg_d = 1'b1;
            end
            6'h0E: begin
                id_ex_op_d = ALU_XOR; id_ex_a_d = rs_val; id_ex_b_d = {16'h0, imm};
                id_ex_waddr_d = rt; id_ex_wreg_d = 1'b1;
            end
            6'h0F: begin
                // lui is an OR of the shifted immediate with zero
                id_ex_op_d = ALU_OR; id_ex_a_d = 32'h0; id_ex_b_d = {imm, 16'h0};
                id_ex_waddr_d = rt; id_ex_wreg_d = 1'b1;
            end
            default: ;
        endcase
        // nop/ssnop encode as shifts into $0; dropping $0 writes keeps them out of forwarding too
        if (id_ex_waddr_d == 5'd0) begin
            id_ex_wreg_d = 1'b0;
        end
    end

    always_comb begin
        ex_result = 32'h0;
        case (id_ex_op_q)
            ALU_AND: ex_result = id_ex_a_q & id_ex_b_q;
            ALU_OR:  ex_result = id_ex_a_q | id_ex_b_q;
            ALU_XOR: ex_result = id_ex_a_q ^ id_ex_b_q;
            ALU_NOR: ex_result = ~(id_ex_a_q | id_ex_b_q);
            ALU_SLL: ex_result = id_ex_b_q << id_ex_a_q[4:0];
            ALU_SRL: ex_result = id_ex_b_q >> id_ex_a_q[4:0];
            ALU_SRA: ex_result = $unsigned($signed(id_ex_b_q) >>> id_ex_a_q[4:0]);
            default: ex_result = 32'h0;
        endcase
    end

    always_comb begin
        ex_mem_wreg_d  = id_ex_wreg_q;
        ex_mem_waddr_d = id_ex_waddr_q;
        ex_mem_wdata_d = ex_result;
        // no memory operations in this subset: MEM is a pure pass-through stage
        mem_wb_wreg_d  = ex_mem_wreg_q;
        mem_wb_waddr_d = ex_mem_waddr_q;
        mem_wb_wdata_d = ex_mem_wdata_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q           <= 32'h0;
            if_id_inst_q   <= 32'h0;
            id_ex_op_q     <= ALU_NOP;
            id_ex_a_q      <= 32'h0;
            id_ex_b_q      <= 32'h0;
            id_ex_wreg_q   <= 1'b0;
            id_ex_waddr_q  <= 5'd0;
            ex_mem_wreg_q  <= 1'b0;
            ex_mem_waddr_q <= 5'd0;
            ex_mem_wdata_q <= 32'h0;
            mem_wb_wreg_q  <= 1'b0;
            mem_wb_waddr_q <= 5'd0;
            mem_wb_wdata_q <= 32'h0;
        end else begin
            pc_q           <= pc_d;
            if_id_inst_q   <= if_id_inst_d;
            id_ex_op_q     <= id_ex_op_d;
            id_ex_a_q      <= id_ex_a_d;
            id_ex_b_q      <= id_ex_b_d;
            id_ex_wreg_q   <= id_ex_wreg_d;
            id_ex_waddr_q  <= id_ex_waddr_d;
            ex_mem_wreg_q  <= ex_mem_wreg_d;
            ex_mem_waddr_q <= ex_mem_waddr_d;
            ex_mem_wdata_q <= ex_mem_wdata_d;
            mem_wb_wreg_q  <= mem_wb_wreg_d;
            mem_wb_waddr_q <= mem_wb_waddr_d;
            mem_wb_wdata_q <= mem_wb_wdata_d;
        end
    end
endmodule

// Purpose: SoPC top tying the core's fetch port to the instruction ROM.
// Latency: one instruction retires per cycle, 5 edges after its fetch begins.
// Backpressure: none.
module mips_sopc #(
    parameter int ROM_DEPTH = 1024
) (
    input logic clock,
    input logic reset
);
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        rom_ce;

    mips_core cpu (
        .clock      (clock),
        .reset      (reset),
        .rom_inst_i (rom_inst),
        .rom_addr_o (rom_addr),
        .rom_ce_o   (rom_ce)
    );

    mips_rom #(.DEPTH(ROM_DEPTH)) rom (
        .ce_i   (rom_ce),
        .addr_i (rom_addr),
        .inst_o (rom_inst)
    );
endmodule

// File: tb/tb_mips_sopc.sv
// Testbench for mips_sopc: directed program with an edge-indexed expectation table,
// a mid-run reset sequence, and a random program checked against an ISA-level model.
module tb_mips_sopc;
    logic clock = 1'b0;
    logic reset = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int cur_edge    = 0;

    typedef struct {
        int          edge_n;
        logic [4:0]  rno;
        logic [31:0] val;
    } chk_t;

    chk_t              tbl[$];
    logic [31:0]       prog[$];
    logic [31:0]       mregs [0:31];
    logic [7:0][31:0]  snaps[$];

    mips_sopc #(.ROM_DEPTH(1024)) dut (
        .clock (clock),
        .reset (reset)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] gpr(input logic [4:0] r);
        return dut.cpu.register.storage[r];
    endfunction

    function automatic logic [31:0] gpr_or();
        logic [31:0] acc;
        acc = 32'h0;
        for (int i = 0; i < 32; i++) acc |= dut.cpu.register.storage[5'(i)];
        return acc;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h required %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cur_edge++;
    endtask

    task automatic run_to(input int e);
        while (cur_edge < e) tick();
    endtask

    task automatic add(input int e, input logic [4:0] r, input logic [31:0] v);
        chk_t c;
        c.edge_n = e;
        c.rno    = r;
        c.val    = v;
        tbl.push_back(c);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 1024; i++)
            dut.rom.storage[10'(i)] = (i < prog.size()) ? prog[i] : 32'h0;
    endtask

    // Reset held 10 cycles with the program loaded underneath, state checked, released on a falling edge.
    task automatic start_run(input string tag);
        reset = 1'b0;
        @(posedge clock);
        load_prog();
        repeat (10) @(posedge clock);
        #1;
        check({tag, "_rst_gpr"}, gpr_or(), 32'h0);
        check({tag, "_rst_pc"}, dut.cpu.pc_q, 32'h0);
        check({tag, "_rst_fetch_blocked"}, dut.rom.inst_o, 32'h0);
        @(negedge clock);
        reset    = 1'b1;
        cur_edge = 0;
    endtask

    // Random-program generator: encodes one instruction and executes it on the ISA model.
    task automatic gen(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input int nsel);
        logic [31:0]      w, res;
        logic [4:0]       dst;
        logic             wr;
        logic [7:0][31:0] s;
        wr = 1'b1; dst = rd; res = 32'h0; w = 32'h0;
        case (kind)
            0:  begin w = enc_r(rs, rt, rd, 5'd0, 6'h24); res = mregs[rs] & mregs[rt]; end
            1:  begin w = enc_r(rs, rt, rd, 5'd0, 6'h25); res = mregs[rs] | mregs[rt]; end
            2:  begin w = enc_r(rs, rt, rd, 5'd0, 6'h26); res = mregs[rs] ^ mregs[rt]; end
            3:  begin w = enc_r(rs, rt, rd, 5'd0, 6'h27); res = ~(mregs[rs] | mregs[rt]); end
            4:  begin w = enc_i(6'h0C, rs, rt, imm); res = mregs[rs] & {16'h0, imm}; dst = rt; end
            5:  begin w = enc_i(6'h0D, rs, rt, imm); res = mregs[rs] | {16'h0, imm}; dst = rt; end
            6:  begin w = enc_i(6'h0E, rs, rt, imm); res = mregs[rs] ^ {16'h0, imm}; dst = rt; end
            7:  begin w = enc_i(6'h0F, 5'd0, rt, imm); res = {imm, 16'h0}; dst = rt; end
            8:  begin w = enc_r(5'd0, rt, rd, sh, 6'h00); res = mregs[rt] << sh; end
            9:  begin w = enc_r(5'd0, rt, rd, sh, 6'h02); res = mregs[rt] >> sh; end
            10: begin w = enc_r(5'd0, rt, rd, sh, 6'h03); res = $signed(mregs[rt]) >>> sh; end
            11: begin w = enc_r(rs, rt, rd, 5'd0, 6'h04); res = mregs[rt] << mregs[rs][4:0]; end
            12: begin w = enc_r(rs, rt, rd, 5'd0, 6'h06); res = mregs[rt] >> mregs[rs][4:0]; end
            13: begin w = enc_r(rs, rt, rd, 5'd0, 6'h07); res = $signed(mregs[rt]) >>> mregs[rs][4:0]; end
            default: begin
                wr = 1'b0;
                case (nsel)
                    0:       w = 32'h0000_0000;
                    1:       w = 32'h0000_0040;
                    2:       w = 32'h0000_000F;
                    3:       w = enc_i(6'h33, rs, rt, imm);
                    4:       w = enc_i(6'h23, rs, rt, imm);
                    default: w = enc_r(rs, rt, rd, 5'd0, 6'h20);
                endcase
            end
        endcase
        prog.push_back(w);
        if (wr && (dst != 5'd0)) mregs[dst] = res;
        for (int r = 0; r < 8; r++) s[3'(r)] = mregs[5'(r)];
        snaps.push_back(s);
    endtask

    initial begin
        // ---------------- directed program ----------------
        prog.push_back(enc_i(6'h0F, 5'd0, 5'd2, 16'h0404));   // 0  lui  $2,0x0404
        prog.push_back(enc_i(6'h0D, 5'd2, 5'd2, 16'h0404));   // 1  ori  $2,$2,0x0404
        prog.push_back(enc_i(6'h0D, 5'd0, 5'd7, 16'h0007));   // 2  ori  $7,$0,7
        prog.push_back(enc_i(6'h0D, 5'd0, 5'd5, 16'h0005));   // 3  ori  $5,$0,5
        prog.push_back(enc_i(6'h0D, 5'd0, 5'd8, 16'h0008));   // 4  ori  $8,$0,8
        prog.push_back(32'h0000_000F);                        // 5  sync
        prog.push_back(enc_r(5'd0, 5'd2, 5'd2, 5'd8, 6'h00)); // 6  sll  $2,$2,8
        prog.push_back(enc_r(5'd7, 5'd2, 5'd2, 5'd0, 6'h04)); // 7  sllv $2,$2,$7
        prog.push_back(enc_r(5'd0, 5'd2, 5'd2, 5'd8, 6'h02)); // 8  srl  $2,$2,8
        prog.push_back(enc_r(5'd5, 5'd2, 5'd2, 5'd0, 6'h06)); // 9  srlv $2,$2,$5
        prog.push_back(32'h0000_0000);                        // 10 nop
        prog.push_back(enc_i(6'h33, 5'd2, 5'd4, 16'h0010));   // 11 pref
        prog.push_back(enc_r(5'd0, 5'd2, 5'd2, 5'd19, 6'h00));// 12 sll  $2,$2,19
        prog.push_back(32'h0000_0040);                        // 13 ssnop
        prog.push_back(enc_r(5'd0, 5'd2, 5'd2, 5'd16, 6'h03));// 14 sra  $2,$2,16
        prog.push_back(enc_r(5'd8, 5'd2, 5'd2, 5'd0, 6'h07)); // 15 srav $2,$2,$8
        prog.push_back(enc_i(6'h0E, 5'd2, 5'd3, 16'hFFFF));   // 16 xori $3,$2,0xffff
        prog.push_back(enc_i(6'h0C, 5'd3, 5'd4, 16'h0FF0));   // 17 andi $4,$3,0x0ff0
        prog.push_back(enc_r(5'd3, 5'd5, 5'd6, 5'd0, 6'h27)); // 18 nor  $6,$3,$5
        prog.push_back(enc_r(5'd6, 5'd2, 5'd9, 5'd0, 6'h24)); // 19 and  $9,$6,$2
        prog.push_back(enc_i(6'h0D, 5'd7, 5'd0, 16'h1234));   // 20 ori  $0,$7,0x1234
        prog.push_back(enc_r(5'd0, 5'd7, 5'd10, 5'd0, 6'h25));// 21 or   $10,$0,$7
        prog.push_back(enc_r(5'd10, 5'd8, 5'd11, 5'd0, 6'h26));// 22 xor $11,$10,$8

        add(4, 5'd2, 32'h0000_0000);
        add(5, 5'd2, 32'h0404_0000);
        add(6, 5'd2, 32'h0404_0404);
        add(7, 5'd7, 32'h0000_0007);
        add(8, 5'd5, 32'h0000_0005);
        add(9, 5'd8, 32'h0000_0008);
        add(10, 5'd2, 32'h0404_0404);
        add(10, 5'd7, 32'h0000_0007);
        add(10, 5'd5, 32'h0000_0005);
        add(10, 5'd8, 32'h0000_0008);
        add(11, 5'd2, 32'h0404_0400);
        add(12, 5'd2, 32'h0202_0000);
        add(13, 5'd2, 32'h0002_0200);
        add(14, 5'd2, 32'h0000_1010);
        add(15, 5'd2, 32'h0000_1010);
        add(16, 5'd2, 32'h0000_1010);
        add(16, 5'd5, 32'h0000_0005);
        add(16, 5'd7, 32'h0000_0007);
        add(16, 5'd8, 32'h0000_0008);
        add(16, 5'd4, 32'h0000_0000);
        add(17, 5'd2, 32'h8080_0000);
        add(18, 5'd2, 32'h8080_0000);
        add(19, 5'd2, 32'hFFFF_8080);
        add(20, 5'd2, 32'hFFFF_FF80);
        add(21, 5'd3, 32'hFFFF_007F);
        add(22, 5'd4, 32'h0000_0070);
        add(23, 5'd6, 32'h0000_FF80);
        add(24, 5'd9, 32'h0000_FF80);
        add(25, 5'd0, 32'h0000_0000);
        add(26, 5'd10, 32'h0000_0007);
        add(27, 5'd11, 32'h0000_000F);

        start_run("dir");
        for (int i = 0; i < tbl.size(); i++) begin
            run_to(tbl[i].edge_n);
            check($sformatf("dir_e%0d_r%0d", tbl[i].edge_n, tbl[i].rno), gpr(tbl[i].rno), tbl[i].val);
        end

        // ---------------- mid-run reset ----------------
        start_run("mid");
        run_to(8);
        check("mid_pre_r5", gpr(5'd5), 32'h0000_0005);
        #1;
        reset = 1'b0;          // asserted between edges: must act without a clock
        #1;
        check("mid_async_gpr", gpr_or(), 32'h0);
        check("mid_async_pc", dut.cpu.pc_q, 32'h0);
        check("mid_async_ifid", dut.cpu.if_id_inst_q, 32'h0);
        check("mid_async_fetch", dut.rom.inst_o, 32'h0);
        tick();
        tick();
        check("mid_inflight_r8", gpr(5'd8), 32'h0);
        check("mid_held_pc", dut.cpu.pc_q, 32'h0);
        @(negedge clock);
        reset    = 1'b1;
        cur_edge = 0;
        run_to(4);
        check("mid_restart_e4_r2", gpr(5'd2), 32'h0);
        run_to(5);
        check("mid_restart_e5_r2", gpr(5'd2), 32'h0404_0000);
        run_to(9);
        check("mid_restart_e9_r8", gpr(5'd8), 32'h0000_0008);

        // ---------------- random program vs ISA model ----------------
        prog.delete();
        snaps.delete();
        for (int r = 0; r < 32; r++) mregs[5'(r)] = 32'h0;
        for (int r = 1; r < 8; r++) begin
            gen(7, 5'd0, 5'(r), 5'd0, 5'd0, 16'($urandom), 0);
            gen(5, 5'(r), 5'(r), 5'd0, 5'd0, 16'($urandom), 0);
        end
        for (int n = 0; n < 200; n++) begin
            gen(int'($urandom_range(0, 14)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom), 16'($urandom),
                int'($urandom_range(0, 5)));
        end
        start_run("rnd");
        for (int k = 0; k < snaps.size(); k++) begin
            run_to(k + 5);
            for (int r = 0; r < 8; r++)
                check($sformatf("rnd_i%0d_r%0d", k, r), gpr(5'(r)), snaps[k][3'(r)]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mips_sopc.md
# mips_sopc

Minimal MIPS32 system-on-programmable-chip: a 5-stage pipelined integer core, instance `cpu`, plus a word-organised instruction ROM, instance `rom`, behind a single clock/reset pair. It executes the logic, LUI and shift subset of MIPS32 from ROM and updates its general-purpose register file. It is the top of the core test environment. Benches preload the ROM and observe results through hierarchical references only.

## Interface
- `ROM_DEPTH`, 1024: ROM size in 32-bit words.
- `clock`  input  1  single system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- Required hierarchy, since benches reference it directly:
  - `rom.storage[0:ROM_DEPTH-1]`: 32-bit words, loadable by `$readmemh`.
  - `cpu.register.storage[0:31]`: 32-bit general-purpose registers.

## Operation
- **ROM**
  - Combinational read of `storage[pc[..:2]]`.
  - Outputs 0 while the fetch enable is low, i.e. during reset.
- **Pipeline stages:** IF, ID, EX, MEM, WB, separated by pipeline registers. No stalls are needed for this subset.
- **Reset state**
  - PC = 0 and all pipeline registers cleared (NOP, no write).
  - All 32 GPRs cleared to 0.
- **Register file**
  - Two read ports and one write port.
  - Write occurs in WB; writes to $0 are ignored and $0 always reads 0.
  - A same-cycle write/read of the same register returns the new value (write-through).
- **Forwarding into ID operand selection**, priority EX result > MEM result > register file. Back-to-back dependent instructions must execute correctly with no bubbles.
- **Supported instructions**
  - R-type `and`, `or`, `xor`, `nor`: rd = rs op rt.
  - `andi`, `ori`, `xori`: rt = rs op zero-extended imm16.
  - `lui`: rt = {imm16, 16'h0}.
  - `sll`, `srl`, `sra`: rd = rt shifted by shamt, bits [10:6].
  - `sllv`, `srlv`, `srav`: rd = rt shifted by rs[4:0].
  - `sra`/`srav` replicate bit 31; `srl`/`srlv` fill with zeros.
- **No-ops**
  - `nop` (0x00000000), `ssnop` (0x00000040), `sync` (0x0000000F) and `pref` (opcode 0x33) perform no register write.
  - Any unrecognised encoding is likewise treated as a no-op; it has no trap and no side effects.
- **Arithmetic:** all operations are 32-bit and results are truncated to 32 bits.
- **PC:** increments by 4 each cycle. No branches; fetch wraps modulo ROM_DEPTH.

## Timing
- **Retirement:** one instruction retires per cycle in steady state.
- **Latency:** the instruction at word address k writes its destination on the (k+5)th rising `clock` edge after `reset` deasserts.
- **Reset assertion mid-run:** immediately (asynchronously)
  - clears PC, the pipeline and the GPRs;
  - blocks fetch until release;
  - suppresses any in-flight write-back.
- **Forwarding results:**
  - An instruction in EX provides its result to the consumer in ID in the same cycle.
  - An instruction in MEM likewise provides its result to the consumer in ID in the same cycle.
  - WB provides its result via register-file write-through.

## Test plan
- **Reset:** hold `reset` low 10 cycles, then check every GPR = 0, PC = 0 and no writes before edge 5 after release.
- **Program `lui $2,0x0404; ori $2,$2,0x0404; ori $7,$0,7; ori $5,$0,5; ori $8,$0,8; sync`:**
  - Checks, one per edge: edge 5 r2=0x04040000; edge 6 r2=0x04040404; edge 7 r7=7; edge 8 r5=5; edge 9 r8=8.
  - Edge 10 (`sync`): all four registers unchanged.
- **Continuing `sll $2,$2,8; sllv $2,$2,$7; srl $2,$2,8; srlv $2,$2,$5`:** r2 = 0x04040400, 0x02020000, 0x00020200, 0x00001010 on consecutive edges. This exercises EX forwarding.
- **Continuing `nop; pref`:** r2 stays 0x00001010 and r5/r7/r8 stay 5/7/8.
- **Continuing `sll $2,$2,19; ssnop; sra $2,$2,16; srav $2,$2,$8`:** r2 = 0x80800000, 0x80800000, 0xffff8080, 0xffffff80 on consecutive edges. This covers sign fill and a MEM-distance dependency across the `ssnop`.
- **Logic ops, $0 and mid-run reset:**
  - `xori`/`andi`/`nor`/`and` on known operands must give the bitwise-correct results.
  - A write to $0 must leave it 0.
  - Asserting `reset` mid-program must clear the GPRs and restart fetch from address 0 after release.
